// File: rtl/inv_subbytes_seq_pkg.sv
// Shared AES constants and the control FSM encoding for the sequential InvSubBytes block.
package inv_subbytes_seq_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

endpackage

// File: rtl/inv_subbytes_seq_if.sv
// Valid/ready input and output channels of the InvSubBytes block.
interface inv_subbytes_seq_if;
  import inv_subbytes_seq_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/inv_subbytes_seq_sbox.sv
// AES inverse S-box: 8-bit combinational lookup, table entry 0 in the top byte.
module inverseSbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [2047:0] Table = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry n sits at bit offset 8*(255-n), and 255-n is just ~n.
  assign dout = Table[{~din, 3'b000} +: 8];

endmodule

// File: rtl/inv_subbytes_seq.sv
// InvSubBytes over a 128-bit state using LANES S-boxes, LANES bytes per cycle.
module inv_subbytes_seq
  import inv_subbytes_seq_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  inv_subbytes_seq_if.slave  bus,
  output logic               busy
);

  localparam int unsigned BEATS = AES_BYTES / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_subbytes_seq: LANES must be one of 1, 2, 4, 8, 16");
  end

  fsm_e                   state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [AES_STATE_W-1:0] sreg_q, sreg_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i] = sreg_q[8 * (int'(beat_q) * LANES + i) +: 8];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    inverseSbox u_sbox (
      .din  (lane_in[i]),
      .dout (lane_out[i])
    );
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    sreg_d        = sreg_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          sreg_d  = bus.in_data;
          beat_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          sreg_d[8 * (int'(beat_q) * LANES + i) +: 8] = lane_out[i];
        end
        if (beat_q == BW'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // Accepting in the same cycle the result drains gives back-to-back blocks.
        if (bus.out_ready) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            sreg_d  = bus.in_data;
            beat_d  = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sreg_q  <= sreg_d;
    end
  end

  assign bus.out_data = sreg_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: five instances (LANES=1..16) checked each cycle against a GF(2^8) model.
module tb_inv_subbytes_seq;

  localparam int NDUT = 5;
  localparam int MAIN = 2;  // LANES=4 instance

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NDUT-1:0] iv, ordy, ir, ov, bz;
  logic [127:0]    id [NDUT];
  logic [127:0]    od [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_subbytes_seq_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.in_data   = id[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign od[g]         = bus.out_data;
    inv_subbytes_seq #(.LANES(1 << g)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (bz[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: inverse S-box derived from the forward S-box (GF inverse + affine map).
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x ^= 8'h1b;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
    logic [7:0] b = 8'h00;
    if (v != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(v, 8'(y)) == 8'h01) b = 8'(y);
      end
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = inv_tab[s[8*j +: 8]];
    return r;
  endfunction

  // Transaction-level expectation per instance: a pending block becomes visible
  // BEATS edges after acceptance and stays until the output handshake.
  logic         pend   [NDUT];
  logic [127:0] exp_d  [NDUT];
  int           rdy_at [NDUT];
  int           edges = 0;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      pend[k] = 1'b0; exp_d[k] = '0; rdy_at[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        logic ev, eir;
        if (rst) begin
          pend[k] = 1'b0;
          check($sformatf("rst_out_valid[%0d]", k), 128'(ov[k]), 128'(1'b0));
          check($sformatf("rst_in_ready[%0d]", k), 128'(ir[k]), 128'(1'b1));
          check($sformatf("rst_busy[%0d]", k), 128'(bz[k]), 128'(1'b0));
          check($sformatf("rst_out_data[%0d]", k), od[k], 128'h0);
        end else begin
          ev  = pend[k] && (edges >= rdy_at[k]);
          eir = !pend[k] || (ev && ordy[k]);
          check($sformatf("out_valid[%0d]", k), 128'(ov[k]), 128'(ev));
          check($sformatf("in_ready[%0d]", k), 128'(ir[k]), 128'(eir));
          check($sformatf("busy[%0d]", k), 128'(bz[k]), 128'(pend[k] && !ev));
          if (ev) check($sformatf("out_data[%0d]", k), od[k], exp_d[k]);
          if (ev && ordy[k]) pend[k] = 1'b0;
          if (iv[k] && eir) begin
            pend[k]   = 1'b1;
            exp_d[k]  = inv_sub(id[k]);
            rdy_at[k] = edges + 1 + (16 >> k);
          end
        end
      end
      edges++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ov[k]) begin
        lat = c;
        break;
      end
    end
  endtask

  // Drive one block into instance k, wait for its result and check latency and data.
  task automatic run_block(input int k, input logic [127:0] din, input logic [127:0] dexp,
                           input int lat_exp, input string name);
    int lat;
    iv[k] = 1'b1;
    id[k] = din;
    tick();
    iv[k] = 1'b0;
    wait_valid(k, lat);
    check({name, "_latency"}, 128'(lat), 128'(lat_exp));
    check({name, "_data"}, od[k], dexp);
    tick();
  endtask

  localparam logic [127:0] VEC2 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] EXP2 = 128'hfbd7f3819ea340bf38a53630d56a0952;

  initial begin
    int lat;
    int lat_tab [NDUT] = '{16, 8, 4, 2, 1};
    logic [127:0] held;
    iv   = '0;
    ordy = '1;
    for (int k = 0; k < NDUT; k++) id[k] = '0;
    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

    check("model_inv_00", 128'(inv_tab[8'h00]), 128'h52);
    check("model_inv_01", 128'(inv_tab[8'h01]), 128'h09);
    check("model_inv_63", 128'(inv_tab[8'h63]), 128'h00);
    check("model_inv_ff", 128'(inv_tab[8'hff]), 128'h7d);

    tick();
    tick();
    rst = 1'b0;
    tick();

    run_block(MAIN, 128'h0, {16{8'h52}}, 4, "t1_zero");
    run_block(MAIN, VEC2, EXP2, 4, "t2_ramp");

    // Back-to-back: second block accepted in the DONE cycle of the first.
    iv[MAIN] = 1'b1;
    id[MAIN] = {16{8'h63}};
    tick();
    id[MAIN] = {16{8'hff}};
    wait_valid(MAIN, lat);
    check("t3_lat1", 128'(lat), 128'd4);
    check("t3_data1", od[MAIN], 128'h0);
    check("t3_in_ready_done", 128'(ir[MAIN]), 128'(1'b1));
    tick();
    iv[MAIN] = 1'b0;
    check("t3_busy_no_bubble", 128'(bz[MAIN]), 128'(1'b1));
    wait_valid(MAIN, lat);
    check("t3_lat2", 128'(lat), 128'd4);
    check("t3_data2", od[MAIN], {16{8'h7d}});
    tick();

    // Backpressure.
    ordy[MAIN] = 1'b0;
    iv[MAIN]   = 1'b1;
    id[MAIN]   = VEC2;
    tick();
    iv[MAIN] = 1'b0;
    wait_valid(MAIN, lat);
    check("t4_lat", 128'(lat), 128'd4);
    held = od[MAIN];
    check("t4_data", held, EXP2);
    iv[MAIN] = 1'b1;
    id[MAIN] = {16{8'h63}};
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_valid", 128'(ov[MAIN]), 128'(1'b1));
      check("t4_hold_data", od[MAIN], held);
      check("t4_hold_in_ready", 128'(ir[MAIN]), 128'(1'b0));
      tick();
    end
    ordy[MAIN] = 1'b1;
    #1;
    check("t4_release_in_ready", 128'(ir[MAIN]), 128'(1'b1));
    tick();
    iv[MAIN] = 1'b0;
    check("t4_accepted_busy", 128'(bz[MAIN]), 128'(1'b1));
    wait_valid(MAIN, lat);
    check("t4_lat2", 128'(lat), 128'd4);
    check("t4_data2", od[MAIN], 128'h0);
    tick();

    // Reset at beat 2.
    iv[MAIN] = 1'b1;
    id[MAIN] = VEC2;
    tick();
    iv[MAIN] = 1'b0;
    tick();
    tick();
    check("t5_busy_before", 128'(bz[MAIN]), 128'(1'b1));
    rst = 1'b1;
    #1;
    check("t5_out_valid", 128'(ov[MAIN]), 128'(1'b0));
    check("t5_in_ready", 128'(ir[MAIN]), 128'(1'b1));
    check("t5_busy", 128'(bz[MAIN]), 128'(1'b0));
    check("t5_out_data", od[MAIN], 128'h0);
    tick();
    rst = 1'b0;
    tick();
    run_block(MAIN, VEC2, EXP2, 4, "t5_fresh");

    // LANES sweep.
    for (int k = 0; k < NDUT; k++) begin
      run_block(k, VEC2, EXP2, lat_tab[k], $sformatf("t6_lanes%0d", 1 << k));
    end

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
